mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction cache (line-fill reads) and the data cache (line-fill reads and write-backs).
- Latches one request at a time and drives it to memory. When memory answers, returns the line to the owning cache.
- Grants alternate round-robin between the two caches so that neither cache starves.
- Sits between the two caches and the memory model; all outputs are registered.

Parameters:
LINE_WIDTH, 128, cache line width in bits
LADDR_WIDTH, 28, line address width (byte address bits 31:4)
TIMEOUT, 64, maximum cycles to wait for mem_rdy before aborting

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
i_req  in  1  iCache line-fill request, level
i_addr  in  LADDR_WIDTH  iCache line address
i_data_rdy  out  1  one-cycle pulse: i_fill_data valid
i_fill_data  out  LINE_WIDTH  line returned to iCache
d_req  in  1  dCache request, level
d_we  in  1  1 = write-back, 0 = line fill
d_addr  in  LADDR_WIDTH  dCache line address
d_wdata  in  LINE_WIDTH  write-back line
d_data_rdy  out  1  one-cycle pulse: dCache transaction complete
d_fill_data  out  LINE_WIDTH  line returned to dCache
mem_req  out  1  memory request, held until mem_rdy
mem_we  out  1  memory write enable
mem_addr  out  LADDR_WIDTH  memory line address
mem_wdata  out  LINE_WIDTH  memory write data
mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_rdy
mem_rdy  in  1  one-cycle pulse: memory transaction done
busy  out  1  1 in any state other than IDLE
timeout_err  out  1  sticky; set on abort, cleared only by reset

Behaviour:
- Reset (reset=0, takes effect immediately):
  - state=IDLE; all outputs 0, including fill-data buses and timeout_err.
  - last_grant=I, so the first simultaneous request goes to D.
  - Reset mid-transaction abandons it; no rdy pulse is produced.
- States: IDLE, MEM, RESP.
- IDLE:
  - Arbitration:
    - If exactly one req is high, grant that requester.
    - If both are high, grant the requester that is not last_grant.
  - On a grant:
    - Latch owner, addr, we (d_we if owner is D, else 0) and wdata (d_wdata if D).
    - Drive mem_req=1, mem_we, mem_addr and mem_wdata from the latched values.
    - Set last_grant=owner, clear the wait counter, go to MEM.
  - mem_req rises the cycle after the req is sampled (1-cycle grant latency).
- MEM:
  - mem_req and mem_* stay stable from the latches; requester inputs are ignored.
  - Wait counter increments each cycle.
  - On mem_rdy=1:
    - mem_req=0.
    - For a read, copy mem_rdata into the owner's fill_data register.
    - Go to RESP.
  - Timeout: if the counter reaches TIMEOUT-1 without mem_rdy:
    - mem_req=0, timeout_err=1.
    - Owner's fill_data is left unchanged; go to RESP.
    - The owner is still released.
- RESP:
  - The owner's data_rdy is 1 for exactly this cycle.
  - fill_data holds its value until overwritten by that owner's next read.
  - D writes do not modify d_fill_data.
  - Next state is IDLE.
- Requester contract:
  - Hold req and addr (and wdata) stable until data_rdy is seen.
  - Drop req by the edge that ends the RESP cycle.
  - A req still high in IDLE is treated as a new request.
- Throughput: back-to-back transactions cost at least 3 cycles plus memory latency (IDLE, MEM×n, RESP).
- Edge cases:
  - A mem_rdy arriving while not in MEM is ignored.
  - A mem_rdy on the same cycle the timeout fires counts as success: data is captured and there is no error.
- Fairness: with both requesters always high, grants strictly alternate D, I, D, I…

Test Plan:
1. Single I read: i_req=1, i_addr=28'h0000001; memory answers 4 cycles after mem_req with mem_rdata=128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> mem_addr=28'h0000001, mem_we=0; i_data_rdy pulses 1 cycle with that data; d_data_rdy stays 0.
2. D write-back: d_req=1, d_we=1, d_addr=28'h0000040, d_wdata=128'h1234…; mem_rdy after 2 cycles -> mem_we=1, mem_wdata=d_wdata; d_data_rdy pulses; d_fill_data unchanged.
3. Simultaneous i_req and d_req held high for 4 transactions after reset -> grant order D, I, D, I; each requester sees exactly 2 rdy pulses.
4. A new i_req arriving during a D transaction -> mem_addr stays equal to d_addr until the D RESP; I is granted on the next IDLE cycle.
5. No mem_rdy for TIMEOUT=64 cycles -> mem_req drops at cycle 64; owner rdy pulses; timeout_err=1 and stays 1 until reset.
6. reset driven low while in MEM -> all outputs 0 immediately, no rdy pulse; after release, a pending request is served normally with D granted first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side and memory-side signals of the memory arbiter.
// The arbiter connects through the slave modport; the caches and the memory
// model connect through the master modport.
interface mem_arbiter_if #(
  parameter int LINE_WIDTH  = 128,
  parameter int LADDR_WIDTH = 28
);

  // iCache side
  logic                   i_req;
  logic [LADDR_WIDTH-1:0] i_addr;
  logic                   i_data_rdy;
  logic [LINE_WIDTH-1:0]  i_fill_data;

  // dCache side
  logic                   d_req;
  logic                   d_we;
  logic [LADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0]  d_wdata;
  logic                   d_data_rdy;
  logic [LINE_WIDTH-1:0]  d_fill_data;

  // memory side
  logic                   mem_req;
  logic                   mem_we;
  logic [LADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0]  mem_wdata;
  logic [LINE_WIDTH-1:0]  mem_rdata;
  logic                   mem_rdy;

  // status
  logic                   busy;
  logic                   timeout_err;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_rdy,
    output i_data_rdy, i_fill_data,
    output d_data_rdy, d_fill_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, timeout_err
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_rdy,
    input  i_data_rdy, i_fill_data,
    input  d_data_rdy, d_fill_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, timeout_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares the single main-memory line port between the iCache
// (line fills) and the dCache (line fills and write-backs). One request is
// latched at a time, driven to memory, and the answer is returned to the owner.
// Simultaneous requests are granted round-robin. All outputs are registered.
module mem_arbiter #(
  parameter int LINE_WIDTH  = 128,
  parameter int LADDR_WIDTH = 28,
  parameter int TIMEOUT     = 64
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  // Wait counter is wide enough to hold TIMEOUT-1 with a spare bit.
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t r_state;
  state_t w_stateNext;

  owner_t r_owner;
  owner_t r_lastGrant;
  owner_t w_grant;
  owner_t w_owner;
  owner_t w_lastGrant;

  logic w_anyReq;
  logic w_memDone;
  logic w_memAbort;

  logic [CW-1:0]          r_waitCnt;
  logic [CW-1:0]          w_waitCnt;

  logic                   r_memReq;
  logic                   r_memWe;
  logic [LADDR_WIDTH-1:0] r_memAddr;
  logic [LINE_WIDTH-1:0]  r_memWdata;
  logic                   r_iRdy;
  logic                   r_dRdy;
  logic [LINE_WIDTH-1:0]  r_iFill;
  logic [LINE_WIDTH-1:0]  r_dFill;
  logic                   r_busy;
  logic                   r_timeoutErr;

  logic                   w_memReq;
  logic                   w_memWe;
  logic [LADDR_WIDTH-1:0] w_memAddr;
  logic [LINE_WIDTH-1:0]  w_memWdata;
  logic                   w_iRdy;
  logic                   w_dRdy;
  logic [LINE_WIDTH-1:0]  w_iFill;
  logic [LINE_WIDTH-1:0]  w_dFill;
  logic                   w_busy;
  logic                   w_timeoutErr;

  // A mem_rdy on the final wait cycle wins over the timeout, and mem_rdy
  // outside MEM is never looked at.
  assign w_anyReq   = bus.i_req | bus.d_req;
  assign w_memDone  = (r_state == MEM) && bus.mem_rdy;
  assign w_memAbort = (r_state == MEM) && !bus.mem_rdy && (r_waitCnt == LAST_WAIT);

  // Round-robin choice: a lone requester wins, otherwise the one not granted last.
  always_comb begin
    w_grant = OWN_I;
    if (bus.i_req && bus.d_req) begin
      w_grant = (r_lastGrant == OWN_I) ? OWN_D : OWN_I;
    end else if (bus.d_req) begin
      w_grant = OWN_D;
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: IDLE -> MEM on a grant, MEM -> RESP on answer or abort, RESP -> IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_stateNext = MEM;
        end
      end
      MEM: begin
        if (w_memDone || w_memAbort) begin
          w_stateNext = RESP;
        end
      end
      RESP: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Next values of every registered output and of the transaction latches.
  always_comb begin
    w_owner      = r_owner;
    w_lastGrant  = r_lastGrant;
    w_waitCnt    = r_waitCnt;
    w_memReq     = r_memReq;
    w_memWe      = r_memWe;
    w_memAddr    = r_memAddr;
    w_memWdata   = r_memWdata;
    w_iRdy       = 1'b0;
    w_dRdy       = 1'b0;
    w_iFill      = r_iFill;
    w_dFill      = r_dFill;
    w_busy       = r_busy;
    w_timeoutErr = r_timeoutErr;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_owner     = w_grant;
          w_lastGrant = w_grant;
          w_waitCnt   = '0;
          w_memReq    = 1'b1;
          w_busy      = 1'b1;
          if (w_grant == OWN_D) begin
            w_memWe    = bus.d_we;
            w_memAddr  = bus.d_addr;
            w_memWdata = bus.d_wdata;
          end else begin
            w_memWe    = 1'b0;
            w_memAddr  = bus.i_addr;
            w_memWdata = '0;
          end
        end
      end
      MEM: begin
        w_waitCnt = r_waitCnt + CW'(1);
        if (w_memDone || w_memAbort) begin
          w_memReq = 1'b0;
          w_memWe  = 1'b0;
          if (r_owner == OWN_D) begin
            w_dRdy = 1'b1;
          end else begin
            w_iRdy = 1'b1;
          end
          if (w_memAbort) begin
            w_timeoutErr = 1'b1;
          end else if (!r_memWe) begin
            if (r_owner == OWN_D) begin
              w_dFill = bus.mem_rdata;
            end else begin
              w_iFill = bus.mem_rdata;
            end
          end
        end
      end
      RESP: begin
        w_busy = 1'b0;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Output and latch registers; last_grant resets to I so D wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= OWN_I;
      r_lastGrant  <= OWN_I;
      r_waitCnt    <= '0;
      r_memReq     <= 1'b0;
      r_memWe      <= 1'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
      r_iRdy       <= 1'b0;
      r_dRdy       <= 1'b0;
      r_iFill      <= '0;
      r_dFill      <= '0;
      r_busy       <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_owner      <= w_owner;
      r_lastGrant  <= w_lastGrant;
      r_waitCnt    <= w_waitCnt;
      r_memReq     <= w_memReq;
      r_memWe      <= w_memWe;
      r_memAddr    <= w_memAddr;
      r_memWdata   <= w_memWdata;
      r_iRdy       <= w_iRdy;
      r_dRdy       <= w_dRdy;
      r_iFill      <= w_iFill;
      r_dFill      <= w_dFill;
      r_busy       <= w_busy;
      r_timeoutErr <= w_timeoutErr;
    end
  end

  assign bus.mem_req     = r_memReq;
  assign bus.mem_we      = r_memWe;
  assign bus.mem_addr    = r_memAddr;
  assign bus.mem_wdata   = r_memWdata;
  assign bus.i_data_rdy  = r_iRdy;
  assign bus.i_fill_data = r_iFill;
  assign bus.d_data_rdy  = r_dRdy;
  assign bus.d_fill_data = r_dFill;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeoutErr;

endmodule
